// File: rtl/mem_slot_arbiter.sv
// ============================================================================
//  Module   : mem_slot_arbiter
//  Purpose  : Fixed-slot DRAM bus arbiter for VID/DSP/BLT/CPU with CPU
//             anti-starvation and bounded blitter burst retention.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_slot_arbiter #(
    parameter int unsigned CYC_LEN    = 3,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic       MCK,
    input  logic       RESETL,
    input  logic       PHSYNC,
    input  logic       VIDREQ,
    input  logic       DSPREQ,
    input  logic       BLTREQ,
    input  logic       CPUREQ,
    input  logic       BLTBURST,
    output logic       VIDGNT,
    output logic       DSPGNT,
    output logic       BLTGNT,
    output logic       CPUGNT,
    output logic       SLOTST,
    output logic       BUSY,
    output logic [1:0] OWNER
);

    typedef enum logic [1:0] {
        OWN_VID = 2'd0,
        OWN_DSP = 2'd1,
        OWN_BLT = 2'd2,
        OWN_CPU = 2'd3
    } owner_t;

    localparam logic [2:0] PH_LAST   = 3'(CYC_LEN - 1);
    localparam logic [3:0] CWAIT_SAT = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    logic [2:0] ph;
    logic [3:0] cwait;
    logic [3:0] bcnt;
    owner_t     owner;
    logic       busy;
    logic [3:0] gnt;        // {CPU, BLT, DSP, VID}
    logic       slotst;

    logic       decision;
    logic       burst_active;
    logic       win_valid;
    owner_t     win;

    assign decision     = (ph == PH_LAST) || PHSYNC;
    assign burst_active = busy && (owner == OWN_BLT) && BLTBURST && BLTREQ
                          && (bcnt < BURST_LIM);

    // Fixed priority; a burst-holding blitter only displaces DSP.
    always_comb begin
        win_valid = 1'b1;
        win       = OWN_VID;
        if (VIDREQ)
            win = OWN_VID;
        else if (DSPREQ && !burst_active)
            win = OWN_DSP;
        else if (CPUREQ && (cwait == CWAIT_SAT))
            win = OWN_CPU;
        else if (BLTREQ)
            win = OWN_BLT;
        else if (CPUREQ)
            win = OWN_CPU;
        else
            win_valid = 1'b0;
    end

    always_ff @(posedge MCK or negedge RESETL) begin
        if (!RESETL) begin
            ph     <= 3'd0;
            cwait  <= 4'd0;
            bcnt   <= 4'd0;
            owner  <= OWN_VID;
            busy   <= 1'b0;
            gnt    <= 4'd0;
            slotst <= 1'b0;
        end else if (decision) begin
            ph     <= 3'd0;
            busy   <= win_valid;
            owner  <= win_valid ? win : OWN_VID;
            gnt    <= win_valid ? (4'b0001 << win) : 4'd0;
            slotst <= win_valid;

            if (!CPUREQ || (win_valid && (win == OWN_CPU)))
                cwait <= 4'd0;
            else if (cwait < CWAIT_SAT)
                cwait <= cwait + 4'd1;

            // Consecutive-slot count only grows while the blitter keeps the bus.
            if (win_valid && (win == OWN_BLT)) begin
                if (busy && (owner == OWN_BLT))
                    bcnt <= (bcnt == 4'hF) ? bcnt : bcnt + 4'd1;
                else
                    bcnt <= 4'd1;
            end else begin
                bcnt <= 4'd0;
            end
        end else begin
            ph     <= ph + 3'd1;
            slotst <= 1'b0;
        end
    end

    assign VIDGNT = gnt[0];
    assign DSPGNT = gnt[1];
    assign BLTGNT = gnt[2];
    assign CPUGNT = gnt[3];
    assign SLOTST = slotst;
    assign BUSY   = busy;
    assign OWNER  = owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_slot_arbiter.sv
// ============================================================================
//  Module   : tb_mem_slot_arbiter
//  Purpose  : Directed + randomized checks of mem_slot_arbiter against a
//             slot-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_slot_arbiter;

    localparam int CYC_LEN    = 3;
    localparam int STARVE_MAX = 8;
    localparam int BURST_MAX  = 4;

    logic       MCK = 1'b0;
    logic       RESETL = 1'b0;
    logic       PHSYNC = 1'b0;
    logic       VIDREQ = 1'b0, DSPREQ = 1'b0, BLTREQ = 1'b0, CPUREQ = 1'b0;
    logic       BLTBURST = 1'b0;
    logic       VIDGNT, DSPGNT, BLTGNT, CPUGNT, SLOTST, BUSY;
    logic [1:0] OWNER;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: slot owner (-1 = idle), phase, CPU wait and burst length.
    int m_ph, m_owner, m_cwait, m_bcnt;
    bit m_slotst;
    int slot_log[$];

    mem_slot_arbiter #(
        .CYC_LEN   (CYC_LEN),
        .STARVE_MAX(STARVE_MAX),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .MCK     (MCK),
        .RESETL  (RESETL),
        .PHSYNC  (PHSYNC),
        .VIDREQ  (VIDREQ),
        .DSPREQ  (DSPREQ),
        .BLTREQ  (BLTREQ),
        .CPUREQ  (CPUREQ),
        .BLTBURST(BLTBURST),
        .VIDGNT  (VIDGNT),
        .DSPGNT  (DSPGNT),
        .BLTGNT  (BLTGNT),
        .CPUGNT  (CPUGNT),
        .SLOTST  (SLOTST),
        .BUSY    (BUSY),
        .OWNER   (OWNER)
    );

    always #5 MCK = ~MCK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {VIDGNT, DSPGNT, BLTGNT, CPUGNT, SLOTST, BUSY, OWNER};
    endfunction

    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        if (m_owner < 0) return 8'd0;
        g = 4'b1000 >> m_owner;
        return {g, m_slotst, 1'b1, 2'(m_owner)};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_owner = -1; m_cwait = 0; m_bcnt = 0; m_slotst = 0;
    endtask

    task automatic model_edge();
        int  w;
        bit  burst;
        if ((m_ph == CYC_LEN - 1) || PHSYNC) begin
            burst = (m_owner == 2) && BLTBURST && BLTREQ && (m_bcnt < BURST_MAX);
            if (VIDREQ)                                  w = 0;
            else if (DSPREQ && !burst)                   w = 1;
            else if (CPUREQ && m_cwait == STARVE_MAX)    w = 3;
            else if (BLTREQ)                             w = 2;
            else if (CPUREQ)                             w = 3;
            else                                         w = -1;
            if (w == 3 || !CPUREQ) m_cwait = 0;
            else if (m_cwait < STARVE_MAX) m_cwait++;
            if (w == 2) m_bcnt = (m_owner == 2) ? ((m_bcnt < 15) ? m_bcnt + 1 : 15) : 1;
            else        m_bcnt = 0;
            m_owner  = w;
            m_slotst = (w >= 0);
            m_ph     = 0;
            if (w >= 0) slot_log.push_back(w);
        end else begin
            m_ph++;
            m_slotst = 0;
        end
    endtask

    task automatic tick();
        @(posedge MCK);
        model_edge();
        @(negedge MCK);
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic set_req(input logic v, input logic d, input logic b, input logic c);
        VIDREQ = v; DSPREQ = d; BLTREQ = b; CPUREQ = c;
    endtask

    task automatic do_reset();
        @(negedge MCK);
        RESETL = 1'b0;
        model_reset();
        #1;
        check("reset_state", dut_vec(), 8'd0);
        @(negedge MCK);
        RESETL = 1'b1;
        slot_log.delete();
    endtask

    initial begin
        model_reset();

        // All four requesting: VID wins the 3rd edge and re-wins back-to-back.
        do_reset();
        set_req(1, 1, 1, 1);
        tick(); tick();
        check("vid_before_edge3", {7'd0, VIDGNT}, 8'd0);
        tick();
        check("vid_first_slot", {3'd0, VIDGNT, SLOTST, BUSY, OWNER}, 8'b0001_1100);
        tick(); tick();
        check("vid_hold", {6'd0, VIDGNT, SLOTST}, 8'b10);
        tick();
        check("vid_again", {6'd0, VIDGNT, SLOTST}, 8'b11);

        // DSP always beats a starving CPU.
        do_reset();
        set_req(0, 1, 1, 1);
        repeat (15 * CYC_LEN) tick();
        check("dsp_slot_count", 8'(slot_log.size()), 8'd15);
        foreach (slot_log[i]) check("dsp_owner", 8'(slot_log[i]), 8'd1);

        // BLT vs CPU: 8 BLT slots then one CPU slot, repeating.
        do_reset();
        set_req(0, 0, 1, 1);
        repeat (20 * CYC_LEN) tick();
        check("bltcpu_slot_count", 8'(slot_log.size()), 8'd20);
        foreach (slot_log[i])
            check("bltcpu_owner", 8'(slot_log[i]), (i % 9 == 8) ? 8'd3 : 8'd2);

        // Blitter burst holds off DSP for 4 slots total.
        do_reset();
        set_req(0, 0, 1, 0);
        BLTBURST = 1'b1;
        repeat (CYC_LEN) tick();
        DSPREQ = 1'b1;
        repeat (5 * CYC_LEN) tick();
        check("burst_slot_count", 8'(slot_log.size()), 8'd6);
        for (int i = 0; i < 6; i++)
            check("burst_owner", 8'(slot_log[i]), (i < 4) ? 8'd2 : 8'd1);

        // VID raised mid-burst takes the next boundary.
        do_reset();
        set_req(0, 0, 1, 0);
        repeat (CYC_LEN) tick();
        DSPREQ = 1'b1;
        repeat (CYC_LEN) tick();
        VIDREQ = 1'b1;
        repeat (CYC_LEN) tick();
        check("vid_breaks_burst", 8'(slot_log[2]), 8'd0);
        check("burst_slot2", 8'(slot_log[1]), 8'd2);
        BLTBURST = 1'b0;

        // PHSYNC at PH=1 truncates the CPU slot and restarts the phase.
        do_reset();
        set_req(0, 0, 0, 1);
        repeat (CYC_LEN) tick();
        check("cpu_granted", {7'd0, CPUGNT}, 8'd1);
        tick();
        PHSYNC = 1'b1;
        tick();
        PHSYNC = 1'b0;
        check("phsync_regrant", {6'd0, CPUGNT, SLOTST}, 8'b11);
        tick();
        check("phsync_strobe_clear", {7'd0, SLOTST}, 8'd0);
        tick(); tick();
        check("post_sync_slot", {6'd0, CPUGNT, SLOTST}, 8'b11);

        // Asynchronous reset mid-slot drops grants without a clock edge.
        tick();
        #2;
        RESETL = 1'b0;
        #1;
        model_reset();
        check("async_drop", {2'd0, VIDGNT, DSPGNT, BLTGNT, CPUGNT, BUSY, SLOTST}, 8'd0);
        @(negedge MCK);
        RESETL = 1'b1;
        tick(); tick();
        check("post_reset_wait", {7'd0, CPUGNT}, 8'd0);
        tick();
        check("post_reset_grant", {7'd0, CPUGNT}, 8'd1);

        // Randomized traffic with occasional PHSYNC and async resets.
        for (int n = 0; n < 800; n++) begin
            VIDREQ   = ($urandom_range(0, 7) == 0);
            DSPREQ   = ($urandom_range(0, 2) == 0);
            BLTREQ   = ($urandom_range(0, 1) == 0);
            CPUREQ   = ($urandom_range(0, 1) == 0);
            BLTBURST = ($urandom_range(0, 3) != 0);
            PHSYNC   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #3;
                RESETL = 1'b0;
                #1;
                model_reset();
                check("rand_async_reset", dut_vec(), 8'd0);
                @(negedge MCK);
                RESETL = 1'b1;
            end
            tick();
        end
        PHSYNC = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
